csr_exec_unit: RTL and testbench

Execution-side endpoint of the CSR issue path. It accepts one CSR instruction at a time from the CSR issue queue, together with the rs1 operand returned by register-file wakeup. It performs the atomic read-modify-write on a machine-mode CSR subset and returns the old CSR value to writeback through a valid/ready handshake. It also owns the free-running mcycle/minstret counters and exports mtvec/mepc to the redirect logic.

---
 rtl/csr_pkg.sv | 42 ++++
 rtl/csr_regfile.sv | 86 ++++++++
 rtl/csr_exec_unit.sv | 180 ++++++++++++++++++
 tb/tb_csr_exec_unit.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// Shared definitions for the CSR execution unit.
//   - CSR address map of the implemented machine-mode subset
//   - CSR op encoding and the illegal-instruction exception code
//   - FSM state enum and the latched request struct
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET = 12'hB02;
  localparam logic [11:0] CSR_CYCLE    = 12'hC00;
  localparam logic [11:0] CSR_INSTRET  = 12'hC02;

  localparam logic [1:0] OP_RSVD = 2'b00;
  localparam logic [1:0] OP_RW   = 2'b01;
  localparam logic [1:0] OP_RS   = 2'b10;
  localparam logic [1:0] OP_RC   = 2'b11;

  localparam logic [3:0] EXC_ILLEGAL_INST = 4'd2;

  // MIE[3], MPIE[7], MPP[12:11]
  localparam logic [63:0] MSTATUS_WMASK = 64'h0000_0000_0000_1888;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StWb
  } csr_state_e;

  // Width-independent part of an accepted instruction; the XLEN/PREG/ROB sized
  // fields are held in separate registers in the top level.
  typedef struct packed {
    logic [11:0] csrid;
    logic [1:0]  op;
    logic        imm_en;
    logic [4:0]  imm;
  } CsrExecReq;

endpackage

// File: rtl/csr_regfile.sv
// Machine-mode CSR storage with write masks and the mcycle/minstret counters.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   i_raddr              read address
//   o_rdata, o_legal     read data, address is implemented
//   i_we, i_waddr,       write strobe, address, data (already legality-checked)
//   i_wdata
//   i_inst_retire        instructions retired this cycle (0..2)
//   o_mtvec, o_mepc      current register values
module csr_regfile
  import csr_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [11:0]     i_raddr,
  output logic [XLEN-1:0] o_rdata,
  output logic            o_legal,
  input  logic            i_we,
  input  logic [11:0]     i_waddr,
  input  logic [XLEN-1:0] i_wdata,
  input  logic [1:0]      i_inst_retire,
  output logic [XLEN-1:0] o_mtvec,
  output logic [XLEN-1:0] o_mepc
);

  logic [XLEN-1:0] r_mstatus;
  logic [XLEN-1:0] r_mtvec;
  logic [XLEN-1:0] r_mscratch;
  logic [XLEN-1:0] r_mepc;
  logic [XLEN-1:0] r_mcause;
  logic [XLEN-1:0] r_mcycle;
  logic [XLEN-1:0] r_minstret;

  logic w_wr_mcycle;
  logic w_wr_minstret;

  assign w_wr_mcycle   = i_we && (i_waddr == CSR_MCYCLE);
  assign w_wr_minstret = i_we && (i_waddr == CSR_MINSTRET);

  always_comb begin
    o_rdata = '0;
    o_legal = 1'b1;
    case (i_raddr)
      CSR_MSTATUS:              o_rdata = r_mstatus;
      CSR_MTVEC:                o_rdata = r_mtvec;
      CSR_MSCRATCH:             o_rdata = r_mscratch;
      CSR_MEPC:                 o_rdata = r_mepc;
      CSR_MCAUSE:               o_rdata = r_mcause;
      CSR_MCYCLE, CSR_CYCLE:    o_rdata = r_mcycle;
      CSR_MINSTRET, CSR_INSTRET: o_rdata = r_minstret;
      default:                  o_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mstatus  <= '0;
      r_mtvec    <= '0;
      r_mscratch <= '0;
      r_mepc     <= '0;
      r_mcause   <= '0;
      r_mcycle   <= '0;
      r_minstret <= '0;
    end else begin
      // A software write replaces the counter and drops this cycle's increment.
      r_mcycle   <= w_wr_mcycle   ? i_wdata : r_mcycle + XLEN'(1);
      r_minstret <= w_wr_minstret ? i_wdata : r_minstret + XLEN'(i_inst_retire);
      if (i_we) begin
        case (i_waddr)
          CSR_MSTATUS:  r_mstatus  <= i_wdata & XLEN'(MSTATUS_WMASK);
          CSR_MTVEC:    r_mtvec    <= {i_wdata[XLEN-1:2], 2'b00};
          CSR_MSCRATCH: r_mscratch <= i_wdata;
          CSR_MEPC:     r_mepc     <= {i_wdata[XLEN-1:1], 1'b0};
          CSR_MCAUSE:   r_mcause   <= i_wdata;
          default:      ;
        endcase
      end
    end
  end

  assign o_mtvec = r_mtvec;
  assign o_mepc  = r_mepc;

endmodule

// File: rtl/csr_exec_unit.sv
// CSR execution unit: accepts one CSR instruction at a time, performs the
// atomic read-modify-write and returns the old value through a valid/ready
// writeback port. Redirects squash an instruction still in EXEC.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   issue_*                       instruction and rs1 operand from the issue queue
//   redirect, redirect_idx        backend flush and its ROB boundary
//   inst_retire                   retire count feeding minstret
//   wb_valid/wb_ready, wb_*       writeback handshake and result
//   mtvec_o, mepc_o               trap vector and exception PC for redirect logic
module csr_exec_unit
  import csr_pkg::*;
#(
  parameter int unsigned XLEN       = 64,
  parameter int unsigned PREG_WIDTH = 7,
  parameter int unsigned ROB_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_en,
  output logic                  issue_ready,
  input  logic [XLEN-1:0]       issue_rdata,
  input  logic [11:0]           issue_csrid,
  input  logic [1:0]            issue_op,
  input  logic                  issue_imm_en,
  input  logic [4:0]            issue_imm,
  input  logic [PREG_WIDTH-1:0] issue_rd,
  input  logic [ROB_WIDTH-1:0]  issue_robIdx,
  input  logic                  redirect,
  input  logic [ROB_WIDTH-1:0]  redirect_idx,
  input  logic [1:0]            inst_retire,
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic [PREG_WIDTH-1:0] wb_rd,
  output logic [ROB_WIDTH-1:0]  wb_robIdx,
  output logic [XLEN-1:0]       wb_data,
  output logic                  wb_exc,
  output logic [3:0]            wb_exccode,
  output logic [XLEN-1:0]       mtvec_o,
  output logic [XLEN-1:0]       mepc_o
);

  csr_state_e r_state, w_state_next;

  CsrExecReq             r_req;
  logic [XLEN-1:0]       r_rdata;
  logic [PREG_WIDTH-1:0] r_rd;
  logic [ROB_WIDTH-1:0]  r_rob;

  logic [PREG_WIDTH-1:0] r_wb_rd;
  logic [ROB_WIDTH-1:0]  r_wb_rob;
  logic [XLEN-1:0]       r_wb_data;
  logic                  r_wb_exc;

  logic            w_accept;
  logic            w_exec_done;
  logic [XLEN-1:0] w_src;
  logic [XLEN-1:0] w_old;
  logic [XLEN-1:0] w_new;
  logic            w_legal;
  logic            w_write_attempt;
  logic            w_illegal;
  logic            w_rob_older;
  logic            w_flush;
  logic            w_we;

  assign w_src = r_req.imm_en ? XLEN'(r_req.imm) : r_rdata;

  always_comb begin
    w_new = w_src;
    case (r_req.op)
      OP_RS:   w_new = w_old | w_src;
      OP_RC:   w_new = w_old & ~w_src;
      default: w_new = w_src;
    endcase
  end

  // RS/RC with a zero source are pure reads and never count as a write.
  assign w_write_attempt = (r_req.op == OP_RW) ||
                           (((r_req.op == OP_RS) || (r_req.op == OP_RC)) && (w_src != '0));
  assign w_illegal = !w_legal || (r_req.op == OP_RSVD) ||
                     ((r_req.csrid[11:10] == 2'b11) && w_write_attempt);

  // Wrap-aware age compare: on a differing direction bit the larger index is older.
  assign w_rob_older =
      (r_rob[ROB_WIDTH-1] == redirect_idx[ROB_WIDTH-1]) ?
      (r_rob[ROB_WIDTH-2:0] < redirect_idx[ROB_WIDTH-2:0]) :
      (r_rob[ROB_WIDTH-2:0] > redirect_idx[ROB_WIDTH-2:0]);
  assign w_flush = redirect && !w_rob_older;

  assign w_we = (r_state == StExec) && !w_flush && !w_illegal && w_write_attempt;

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_exec_done  = 1'b0;
    case (r_state)
      StIdle: begin
        if (issue_en && !redirect) begin
          w_accept     = 1'b1;
          w_state_next = StExec;
        end
      end
      StExec: begin
        if (w_flush) begin
          w_state_next = StIdle;
        end else begin
          w_exec_done  = 1'b1;
          w_state_next = StWb;
        end
      end
      StWb: begin
        if (wb_ready) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_req     <= '0;
      r_rdata   <= '0;
      r_rd      <= '0;
      r_rob     <= '0;
      r_wb_rd   <= '0;
      r_wb_rob  <= '0;
      r_wb_data <= '0;
      r_wb_exc  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_req.csrid  <= issue_csrid;
        r_req.op     <= issue_op;
        r_req.imm_en <= issue_imm_en;
        r_req.imm    <= issue_imm;
        r_rdata      <= issue_rdata;
        r_rd         <= issue_rd;
        r_rob        <= issue_robIdx;
      end
      if (w_exec_done) begin
        r_wb_rd   <= r_rd;
        r_wb_rob  <= r_rob;
        r_wb_data <= w_illegal ? '0 : w_old;
        r_wb_exc  <= w_illegal;
      end
    end
  end

  csr_regfile #(
    .XLEN(XLEN)
  ) u_regfile (
    .clk          (clk),
    .rst          (rst),
    .i_raddr      (r_req.csrid),
    .o_rdata      (w_old),
    .o_legal      (w_legal),
    .i_we         (w_we),
    .i_waddr      (r_req.csrid),
    .i_wdata      (w_new),
    .i_inst_retire(inst_retire),
    .o_mtvec      (mtvec_o),
    .o_mepc       (mepc_o)
  );

  assign issue_ready = (r_state == StIdle);
  assign wb_valid    = (r_state == StWb);
  assign wb_rd       = r_wb_rd;
  assign wb_robIdx   = r_wb_rob;
  assign wb_data     = r_wb_data;
  assign wb_exc      = r_wb_exc;
  assign wb_exccode  = r_wb_exc ? EXC_ILLEGAL_INST : 4'd0;

endmodule

// File: tb/tb_csr_exec_unit.sv
// Self-checking bench for csr_exec_unit: expected writeback results are queued
// at issue time and compared when the unit completes a handshake.
module tb_csr_exec_unit;
  import csr_pkg::*;

  localparam int unsigned XLEN = 64;
  localparam int unsigned PW   = 7;
  localparam int unsigned RBW  = 6;

  logic            clk;
  logic            rst;
  logic            issue_en;
  logic            issue_ready;
  logic [XLEN-1:0] issue_rdata;
  logic [11:0]     issue_csrid;
  logic [1:0]      issue_op;
  logic            issue_imm_en;
  logic [4:0]      issue_imm;
  logic [PW-1:0]   issue_rd;
  logic [RBW-1:0]  issue_robIdx;
  logic            redirect;
  logic [RBW-1:0]  redirect_idx;
  logic [1:0]      inst_retire;
  logic            wb_valid;
  logic            wb_ready;
  logic [PW-1:0]   wb_rd;
  logic [RBW-1:0]  wb_robIdx;
  logic [XLEN-1:0] wb_data;
  logic            wb_exc;
  logic [3:0]      wb_exccode;
  logic [XLEN-1:0] mtvec_o;
  logic [XLEN-1:0] mepc_o;

  csr_exec_unit #(
    .XLEN      (XLEN),
    .PREG_WIDTH(PW),
    .ROB_WIDTH (RBW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .issue_en    (issue_en),
    .issue_ready (issue_ready),
    .issue_rdata (issue_rdata),
    .issue_csrid (issue_csrid),
    .issue_op    (issue_op),
    .issue_imm_en(issue_imm_en),
    .issue_imm   (issue_imm),
    .issue_rd    (issue_rd),
    .issue_robIdx(issue_robIdx),
    .redirect    (redirect),
    .redirect_idx(redirect_idx),
    .inst_retire (inst_retire),
    .wb_valid    (wb_valid),
    .wb_ready    (wb_ready),
    .wb_rd       (wb_rd),
    .wb_robIdx   (wb_robIdx),
    .wb_data     (wb_data),
    .wb_exc      (wb_exc),
    .wb_exccode  (wb_exccode),
    .mtvec_o     (mtvec_o),
    .mepc_o      (mepc_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] data;
    logic        exc;
    logic [6:0]  rd;
    logic [5:0]  rob;
    bit          chk_data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   g_tag   = 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: one pop per completed writeback handshake.
  always @(negedge clk) begin
    if (!rst && wb_valid && wb_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_wb", wb_valid, 1'b0);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.chk_data) check("wb_data", wb_data, mon_e.data);
        check("wb_exc", wb_exc, mon_e.exc);
        check("wb_exccode", wb_exccode, mon_e.exc ? 64'd2 : 64'd0);
        check("wb_rd", wb_rd, mon_e.rd);
        check("wb_robIdx", wb_robIdx, mon_e.rob);
      end
    end
  end

  // Expected data = exp_data + mult*(accept_cycle - ref_cyc - 1) when ref_cyc >= 0.
  task automatic issue(input logic [1:0] op, input logic [11:0] id, input logic [63:0] rdata,
                       input logic imm_en, input logic [4:0] imm, input logic [63:0] exp_data,
                       input logic exp_exc, input bit push, input bit chk, input int ref_cyc,
                       input int mult, output int acc_cyc);
    int   guard = 0;
    exp_t e;
    while (!issue_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    check("issue_ready_wait", issue_ready, 1'b1);
    issue_en     = 1'b1;
    issue_op     = op;
    issue_csrid  = id;
    issue_rdata  = rdata;
    issue_imm_en = imm_en;
    issue_imm    = imm;
    issue_rd     = 7'(g_tag);
    issue_robIdx = 6'(g_tag);
    @(posedge clk); #1;
    acc_cyc  = cyc;
    issue_en = 1'b0;
    e.data     = (ref_cyc >= 0) ? exp_data + 64'(mult * (acc_cyc - ref_cyc - 1)) : exp_data;
    e.exc      = exp_exc;
    e.rd       = 7'(g_tag);
    e.rob      = 6'(g_tag);
    e.chk_data = chk;
    if (push) exp_q.push_back(e);
    g_tag++;
  endtask

  task automatic drain();
    int g = 0;
    while ((exp_q.size() != 0 || !issue_ready) && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    check("drain_pending", exp_q.size(), 0);
  endtask

  task automatic run(input logic [1:0] op, input logic [11:0] id, input logic [63:0] rdata,
                     input logic imm_en, input logic [4:0] imm, input logic [63:0] exp_data,
                     input logic exp_exc);
    int a;
    issue(op, id, rdata, imm_en, imm, exp_data, exp_exc, 1'b1, 1'b1, -1, 0, a);
    drain();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cw, cw2, ca, g;
    rst = 1'b1; issue_en = 1'b0; issue_rdata = '0; issue_csrid = '0; issue_op = '0;
    issue_imm_en = 1'b0; issue_imm = '0; issue_rd = '0; issue_robIdx = '0;
    redirect = 1'b0; redirect_idx = '0; inst_retire = 2'd0; wb_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_issue_ready", issue_ready, 1'b1);
    check("rst_wb_valid", wb_valid, 1'b0);
    check("rst_wb_exc", wb_exc, 1'b0);
    check("rst_wb_data", wb_data, 64'd0);
    check("rst_mtvec", mtvec_o, 64'd0);
    check("rst_mepc", mepc_o, 64'd0);

    // mscratch RW / RS-zero / RC
    run(OP_RW, CSR_MSCRATCH, 64'hDEAD_BEEF, 1'b0, 5'd0, 64'd0, 1'b0);
    run(OP_RS, CSR_MSCRATCH, 64'hFFFF, 1'b1, 5'd0, 64'hDEAD_BEEF, 1'b0);
    run(OP_RS, CSR_MSCRATCH, 64'd0, 1'b0, 5'd0, 64'hDEAD_BEEF, 1'b0);
    run(OP_RC, CSR_MSCRATCH, 64'hFF, 1'b0, 5'd0, 64'hDEAD_BEEF, 1'b0);
    run(OP_RS, CSR_MSCRATCH, 64'd0, 1'b0, 5'd0, 64'hDEAD_BE00, 1'b0);

    // mstatus write mask
    run(OP_RS, CSR_MSTATUS, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 5'd0, 64'd0, 1'b0);
    run(OP_RC, CSR_MSTATUS, 64'd0, 1'b1, 5'd8, 64'h1888, 1'b0);
    run(OP_RS, CSR_MSTATUS, 64'd0, 1'b0, 5'd0, 64'h1880, 1'b0);

    // mtvec / mepc alignment, mcause full width
    run(OP_RW, CSR_MTVEC, 64'h5, 1'b0, 5'd0, 64'd0, 1'b0);
    run(OP_RS, CSR_MTVEC, 64'd0, 1'b0, 5'd0, 64'h4, 1'b0);
    check("mtvec_o", mtvec_o, 64'h4);
    run(OP_RW, CSR_MEPC, 64'hFFFF_0003, 1'b0, 5'd0, 64'd0, 1'b0);
    run(OP_RS, CSR_MEPC, 64'd0, 1'b0, 5'd0, 64'hFFFF_0002, 1'b0);
    check("mepc_o", mepc_o, 64'hFFFF_0002);
    run(OP_RW, CSR_MCAUSE, 64'h8000_0000_0000_000B, 1'b0, 5'd0, 64'd0, 1'b0);
    run(OP_RS, CSR_MCAUSE, 64'd0, 1'b0, 5'd0, 64'h8000_0000_0000_000B, 1'b0);

    // Illegal: read-only counter writes, unimplemented address, reserved op
    run(OP_RW, CSR_CYCLE, 64'h5, 1'b0, 5'd0, 64'd0, 1'b1);
    run(OP_RS, CSR_INSTRET, 64'd0, 1'b1, 5'd1, 64'd0, 1'b1);
    run(OP_RS, 12'h7C0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b1);
    run(OP_RSVD, CSR_MSCRATCH, 64'h99, 1'b0, 5'd0, 64'd0, 1'b1);
    run(OP_RS, CSR_MSCRATCH, 64'd0, 1'b0, 5'd0, 64'hDEAD_BE00, 1'b0);

    // Writeback back-pressure: outputs hold, stray issue ignored
    wb_ready = 1'b0;
    issue(OP_RW, CSR_MSCRATCH, 64'h1111, 1'b0, 5'd0, 64'hDEAD_BE00, 1'b0, 1'b1, 1'b1, -1, 0, ca);
    g = 0;
    while (!wb_valid && g < 10) begin
      @(posedge clk); #1;
      g++;
    end
    for (int i = 0; i < 5; i++) begin
      check("stall_wb_valid", wb_valid, 1'b1);
      check("stall_wb_data", wb_data, 64'hDEAD_BE00);
      check("stall_issue_ready", issue_ready, 1'b0);
      issue_en = 1'b1; issue_op = OP_RW; issue_csrid = CSR_MSCRATCH; issue_rdata = 64'h2222;
      @(posedge clk); #1;
    end
    issue_en = 1'b0;
    wb_ready = 1'b1;
    drain();
    run(OP_RS, CSR_MSCRATCH, 64'd0, 1'b0, 5'd0, 64'h1111, 1'b0);

    // Redirect in EXEC: rob 5 vs boundary 5 is flushed, vs 6 completes
    g_tag = 5;
    issue(OP_RW, CSR_MSCRATCH, 64'hBAD, 1'b0, 5'd0, 64'd0, 1'b0, 1'b0, 1'b0, -1, 0, ca);
    redirect = 1'b1; redirect_idx = 6'd5;
    @(posedge clk); #1;
    redirect = 1'b0;
    check("flush_issue_ready", issue_ready, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check("flush_no_wb", wb_valid, 1'b0);
      @(posedge clk); #1;
    end
    run(OP_RS, CSR_MSCRATCH, 64'd0, 1'b0, 5'd0, 64'h1111, 1'b0);
    g_tag = 5;
    issue(OP_RW, CSR_MSCRATCH, 64'h600D, 1'b0, 5'd0, 64'h1111, 1'b0, 1'b1, 1'b1, -1, 0, ca);
    redirect = 1'b1; redirect_idx = 6'd6;
    @(posedge clk); #1;
    redirect = 1'b0;
    drain();
    run(OP_RS, CSR_MSCRATCH, 64'd0, 1'b0, 5'd0, 64'h600D, 1'b0);

    // Redirect with issue_en in IDLE: not accepted
    issue_en = 1'b1; redirect = 1'b1; issue_op = OP_RW; issue_csrid = CSR_MSCRATCH;
    issue_rdata = 64'hBEEF;
    @(posedge clk); #1;
    issue_en = 1'b0; redirect = 1'b0;
    check("redir_idle_ready", issue_ready, 1'b1);
    run(OP_RS, CSR_MSCRATCH, 64'd0, 1'b0, 5'd0, 64'h600D, 1'b0);

    // Counters: written value wins, then +1 per cycle / +2 per retire cycle
    inst_retire = 2'd2;
    issue(OP_RW, CSR_MCYCLE, 64'd100, 1'b0, 5'd0, 64'd0, 1'b0, 1'b1, 1'b0, -1, 0, cw);
    issue(OP_RW, CSR_MINSTRET, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, 1'b1, 1'b0, -1, 0, cw2);
    issue(OP_RS, CSR_MCYCLE, 64'd0, 1'b0, 5'd0, 64'd100, 1'b0, 1'b1, 1'b1, cw, 1, ca);
    issue(OP_RS, CSR_MINSTRET, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, 1'b1, 1'b1, cw2, 2, ca);
    issue(OP_RS, CSR_CYCLE, 64'd0, 1'b1, 5'd0, 64'd100, 1'b0, 1'b1, 1'b1, cw, 1, ca);
    issue(OP_RS, CSR_INSTRET, 64'd0, 1'b1, 5'd0, 64'd0, 1'b0, 1'b1, 1'b1, cw2, 2, ca);
    drain();
    inst_retire = 2'd0;

    // Reset during EXEC discards the pending write
    issue(OP_RW, CSR_MSCRATCH, 64'h77, 1'b0, 5'd0, 64'd0, 1'b0, 1'b0, 1'b0, -1, 0, ca);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_exec_ready", issue_ready, 1'b1);
    check("rst_exec_wb_valid", wb_valid, 1'b0);
    check("rst_exec_mtvec", mtvec_o, 64'd0);
    run(OP_RS, CSR_MSCRATCH, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
